// File: rtl/sram_pkg.sv
// Shared constants for the SRAM pin-bus responder.
//  - pin widths of the 256Kx8 async SRAM bus
//  - default access counter width
//  - one-hot FSM state encoding
package sram_pkg;

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_WRITE    = 5'b00010,
    ST_RD_WAIT  = 5'b00100,
    ST_RD_DRIVE = 5'b01000,
    ST_CONFLICT = 5'b10000
  } state_e;

endpackage

// File: rtl/sram_pin_sync.sv
// Two-flop synchronizer for asynchronous SRAM pins.
//  clk   : system clock
//  rst   : asynchronous active-low reset; both stages go to all-ones (pins inactive)
//  d     : raw pin values
//  q     : values delayed by two clocks
module sram_pin_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sram_responder.sv
// Device-side emulation of an async 256Kx8 SRAM on its pin bus.
// Pins are sampled through two-flop synchronizers; bytes are held in an
// internal 2**AW x 8 array (upper address bits alias).
//  clk    : system clock
//  rst    : asynchronous active-low reset (array contents preserved)
//  CE/OE/WE : active-low chip/output/write enables
//  ADDR   : address bus, only ADDR[AW-1:0] decoded
//  DATA   : bidirectional data, driven only while serving a read
//  wr_cnt : committed writes, saturating
//  rd_cnt : completed reads, saturating
//  err    : sticky, OE and WE seen low together while CE low
//  busy   : FSM not idle
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CE,
  input  logic              OE,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              err,
  output logic              busy
);

  logic [2:0]        ctl_s;
  logic              ce_s, oe_s, we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;
  logic              unused_addr_hi;

  sram_pin_sync #(.W(3)) u_ctl_sync (
    .clk (clk),
    .rst (rst),
    .d   ({CE, OE, WE}),
    .q   (ctl_s)
  );

  sram_pin_sync #(.W(ADDR_W + DATA_W)) u_bus_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ADDR, DATA}),
    .q   ({addr_s, data_s})
  );

  assign {ce_s, oe_s, we_s} = ctl_s;
  assign unused_addr_hi     = ^addr_s[ADDR_W-1:AW];

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              drive_q, drive_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  logic [DATA_W-1:0] mem [2**AW];

  // No reset on the array: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr_q] <= wdata_q;
    end
  end

  assign mem_rd = mem[addr_s[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    drive_d  = 1'b0;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Capture already in IDLE so a write whose WE rise is seen on the
        // first WRITE cycle still commits a valid address/byte.
        waddr_d = addr_s[AW-1:0];
        wdata_d = data_s;
        if (!ce_s && !oe_s && !we_s) begin
          state_d = ST_CONFLICT;
          err_d   = 1'b1;
        end else if (!ce_s && !we_s) begin
          state_d = ST_WRITE;
        end else if (!ce_s && !oe_s) begin
          state_d = ST_RD_WAIT;
          wait_d  = 3'(RD_LAT);
        end
      end
      ST_WRITE: begin
        waddr_d = addr_s[AW-1:0];
        wdata_d = data_s;
        if (!oe_s) begin
          state_d = ST_CONFLICT;
          err_d   = 1'b1;
        end else if (we_s || ce_s) begin
          // Commit the registered copy: it holds the last sample taken
          // while WE was still low.
          mem_we  = 1'b1;
          state_d = ST_IDLE;
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (oe_s || ce_s) begin
          state_d = ST_IDLE;
        end else if (!we_s) begin
          state_d = ST_CONFLICT;
          err_d   = 1'b1;
        end else if (wait_q == '0) begin
          state_d = ST_RD_DRIVE;
          drive_d = 1'b1;
          dout_d  = mem_rd;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RD_DRIVE: begin
        if (oe_s || ce_s) begin
          state_d = ST_IDLE;
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
        end else if (!we_s) begin
          state_d = ST_CONFLICT;
          err_d   = 1'b1;
        end else begin
          drive_d = 1'b1;
          dout_d  = mem_rd;
        end
      end
      ST_CONFLICT: begin
        if (ce_s || (oe_s && we_s)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      drive_q  <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      drive_q  <= drive_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign DATA   = drive_q ? dout_q : 'z;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (AW=8, RD_LAT=1, CNT_W=4).
// A released DATA bus is pulled up, so "not driven" reads as 8'hFF.
module tb_sram_responder;

  localparam int AW      = 8;
  localparam int RD_LAT  = 1;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        CE, OE, WE;
  logic [17:0] ADDR;
  wire  [7:0]  DATA;
  logic        tb_drv;
  logic [7:0]  tb_dat;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic        err, busy;

  assign DATA = tb_drv ? tb_dat : 8'bz;
  pullup (DATA);

  sram_responder #(.AW(AW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .CE     (CE),
    .OE     (OE),
    .WE     (WE),
    .ADDR   (ADDR),
    .DATA   (DATA),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: byte array with valid flags, saturating counts, sticky error.
  logic [7:0]  mdl_mem [256];
  bit          mdl_vld [256];
  int          mdl_wr, mdl_rd;
  bit          mdl_err;
  logic [17:0] rd_addr [16];

  function automatic int sat(input int x);
    return (x < CNT_MAX) ? x + 1 : x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_status(input string nm);
    check({nm, "_wr_cnt"}, 32'(wr_cnt), 32'(mdl_wr));
    check({nm, "_rd_cnt"}, 32'(rd_cnt), 32'(mdl_rd));
    check({nm, "_err"},    32'(err),    32'(mdl_err));
    check({nm, "_busy"},   32'(busy),   32'd0);
  endtask

  task automatic model_write(input logic [17:0] a, input logic [7:0] d);
    mdl_mem[a[AW-1:0]] = d;
    mdl_vld[a[AW-1:0]] = 1'b1;
    mdl_wr = sat(mdl_wr);
  endtask

  // Called just after a falling edge. WE/CE low for L clocks, then both rise together.
  task automatic do_write(input logic [17:0] a, input logic [7:0] d, input int L);
    CE = 1'b0; WE = 1'b0; ADDR = a; tb_dat = d; tb_drv = 1'b1;
    repeat (L) @(negedge clk);
    WE = 1'b1; CE = 1'b1; tb_drv = 1'b0; ADDR = 18'($urandom);
    repeat (3) @(negedge clk);
    model_write(a, d);
    check_status("wr");
  endtask

  // OE/CE low for L clocks; address at falling edge j is rd_addr[j].
  // Data valid after edge n+3+RD_LAT, released at edge n+L+2 (n = first edge seeing OE low):
  // observed on falling edges k = 4+RD_LAT .. L+2 counted from the start.
  task automatic do_read(input int L, input bit use_fixed, input logic [7:0] fixed);
    bit         counted;
    bit         drv;
    logic [7:0] exp;
    counted = (L + 2 >= 4 + RD_LAT);
    CE = 1'b0; OE = 1'b0; ADDR = rd_addr[0];
    for (int k = 1; k <= L + 3; k++) begin
      @(negedge clk);
      drv = counted && (k >= 4 + RD_LAT) && (k <= L + 2);
      if (drv) begin
        exp = use_fixed ? fixed : mdl_mem[rd_addr[k-3][AW-1:0]];
        if (use_fixed || mdl_vld[rd_addr[k-3][AW-1:0]])
          check("rd_data", 32'(DATA), 32'(exp));
      end else begin
        check("rd_undriven", 32'(DATA), 32'hFF);
      end
      if (k < L) ADDR = rd_addr[k];
      else if (k == L) begin
        OE = 1'b1; CE = 1'b1; ADDR = 18'($urandom);
      end
    end
    if (counted) mdl_rd = sat(mdl_rd);
    check_status("rd");
  endtask

  task automatic fill_addr(input logic [17:0] a);
    for (int j = 0; j < 16; j++) rd_addr[j] = a;
  endtask

  task automatic do_reset();
    CE = 1'b1; OE = 1'b1; WE = 1'b1; tb_drv = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mdl_wr = 0; mdl_rd = 0; mdl_err = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [17:0] addr;
    logic [7:0]  data;
    int          len;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t tv [11];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CE = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = '0; tb_drv = 1'b0; tb_dat = '0;
    mdl_wr = 0; mdl_rd = 0; mdl_err = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_data",   32'(DATA),   32'hFF);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table: basic write/read, aliasing, short read abort.
    tv[0]  = '{1'b1, 18'h00001, 8'hAA, 4, 1, 0};
    tv[1]  = '{1'b0, 18'h00001, 8'hAA, 6, 1, 1};
    tv[2]  = '{1'b1, 18'h00101, 8'h5C, 3, 2, 1};
    tv[3]  = '{1'b0, 18'h00001, 8'h5C, 4, 2, 2};
    tv[4]  = '{1'b1, 18'h3FF80, 8'h3C, 5, 3, 2};
    tv[5]  = '{1'b0, 18'h00080, 8'h3C, 3, 3, 3};
    tv[6]  = '{1'b0, 18'h00001, 8'h5C, 2, 3, 3};
    tv[7]  = '{1'b1, 18'h00000, 8'h07, 3, 4, 3};
    tv[8]  = '{1'b0, 18'h3FF00, 8'h07, 5, 4, 4};
    tv[9]  = '{1'b0, 18'h00001, 8'h5C, 1, 4, 4};
    tv[10] = '{1'b1, 18'h2A022, 8'h6B, 6, 5, 4};
    for (int i = 0; i < 11; i++) begin
      if (tv[i].wr) do_write(tv[i].addr, tv[i].data, tv[i].len);
      else begin
        fill_addr(tv[i].addr);
        do_read(tv[i].len, 1'b1, tv[i].data);
      end
      check("tbl_wr_cnt", 32'(wr_cnt), 32'(tv[i].exp_wr));
      check("tbl_rd_cnt", 32'(rd_cnt), 32'(tv[i].exp_rd));
    end

    // Write then read of the same address back to back (CE held low).
    CE = 1'b0; WE = 1'b0; ADDR = 18'h00033; tb_dat = 8'hE1; tb_drv = 1'b1;
    repeat (3) @(negedge clk);
    WE = 1'b1; tb_drv = 1'b0;
    @(negedge clk);
    model_write(18'h00033, 8'hE1);
    fill_addr(18'h00033);
    do_read(5, 1'b1, 8'hE1);
    check("b2b_wr_cnt", 32'(wr_cnt), 32'd6);

    // OE and WE low together: sticky error, bus stays released, no commit.
    CE = 1'b0; OE = 1'b0; WE = 1'b0; ADDR = 18'h00022;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("conf_data", 32'(DATA), 32'hFF);
    end
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    repeat (3) @(negedge clk);
    mdl_err = 1'b1;
    check_status("conf");
    fill_addr(18'h00022);
    do_read(4, 1'b1, 8'h6B);
    check("conf_err_sticky", 32'(err), 32'd1);

    // Reset while driving a read: bus released at once, counters cleared, array kept.
    CE = 1'b0; OE = 1'b0; ADDR = 18'h00022;
    repeat (6) @(negedge clk);
    check("mid_data", 32'(DATA), 32'h6B);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_data",   32'(DATA),   32'hFF);
    check("mid_rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("mid_rst_err",    32'(err),    32'd0);
    CE = 1'b1; OE = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mdl_wr = 0; mdl_rd = 0; mdl_err = 1'b0;
    check_status("after_rst");
    fill_addr(18'h00022);
    do_read(4, 1'b1, 8'h6B);

    // Saturation: 17 writes into 4-bit counter, then an address sweep while driving.
    do_reset();
    for (int i = 0; i < 17; i++)
      do_write(18'(i % 4), 8'(8'h40 + 8'(i)), 3);
    check("sat_wr_cnt", 32'(wr_cnt), 32'hF);
    rd_addr[0] = 18'd0; rd_addr[1] = 18'd0; rd_addr[2] = 18'd0; rd_addr[3] = 18'd0;
    rd_addr[4] = 18'd1; rd_addr[5] = 18'd2; rd_addr[6] = 18'd3; rd_addr[7] = 18'd3;
    rd_addr[8] = 18'd2; rd_addr[9] = 18'd0;
    do_read(10, 1'b0, 8'h00);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 5) begin
        do_write({10'($urandom), 8'($urandom_range(0, 15))}, 8'($urandom),
                 int'($urandom_range(3, 6)));
      end else begin
        rd_addr[0] = {10'($urandom), 8'($urandom_range(0, 15))};
        for (int j = 1; j < 16; j++)
          rd_addr[j] = ($urandom_range(0, 3) == 0) ? {10'($urandom), 8'($urandom_range(0, 15))}
                                                   : rd_addr[j-1];
        do_read(int'($urandom_range(1, 9)), 1'b0, 8'h00);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
